// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the I-memory read handshake and feeds the IR.
// Latency: a response with no stall loads the IR in the same cycle; the next request goes out on the following cycle.
// Backpressure: a stall at response time parks the word in a one-entry buffer and suspends requests until stall drops.
module fetch_ctrl #(
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter logic [15:0] FLUSH_NOP = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ir_load,
    output logic [15:0] ir_in,
    output logic        ir_valid,
    output logic [15:0] pc_out
);

    // FETCH: request outstanding. HOLD: word parked, waiting for stall to drop.
    // DRAIN: redirect arrived mid-request; finish the old read, then jump.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] hold_buf;
    logic [15:0] tgt;
    logic [15:0] redirect_tgt;
    logic [15:0] pc_next;

    // Instructions are halfword aligned, so the target's low bit is dropped.
    assign redirect_tgt = redirect_pc & 16'hFFFE;
    // Sequential fetch wraps naturally at 16 bits.
    assign pc_next      = pc + 16'd2;

    // The address stays on pc in every state; DRAIN never moves pc until the old read completes.
    assign imem_address = pc;
    assign imem_read    = !reset && (state != HOLD);

    // IR write port: flush on reset/redirect, otherwise pass the arriving or parked word when downstream accepts.
    always_comb begin
        ir_load = 1'b0;
        ir_in   = FLUSH_NOP;
        if (reset || redirect) begin
            ir_load = 1'b1;
            ir_in   = FLUSH_NOP;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_resp && !stall) begin
                        ir_load = 1'b1;
                        ir_in   = imem_rdata;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ir_load = 1'b1;
                        ir_in   = hold_buf;
                    end
                end
                default: begin
                    ir_load = 1'b0;
                    ir_in   = FLUSH_NOP;
                end
            endcase
        end
    end

    // Sequencer state, fetch PC, parked word, pending redirect target and IR tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= PC_RESET;
            hold_buf <= 16'h0000;
            tgt      <= 16'h0000;
            pc_out   <= 16'h0000;
            ir_valid <= 1'b0;
        end else begin
            // A redirect always flushes the IR, whatever the state.
            if (redirect) begin
                ir_valid <= 1'b0;
            end
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (imem_resp) begin
                            // Read finished this cycle; its data is stale, jump right away.
                            pc <= redirect_tgt;
                        end else begin
                            // Read still in flight; it must complete on the old address first.
                            tgt   <= redirect_tgt;
                            state <= DRAIN;
                        end
                    end else if (imem_resp) begin
                        if (stall) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            pc_out   <= pc;
                            ir_valid <= 1'b1;
                            pc       <= pc_next;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_tgt;
                        state <= FETCH;
                    end else if (!stall) begin
                        pc_out   <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc_next;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_resp) begin
                        // Old read done; go to the newest target seen.
                        pc    <= redirect ? redirect_tgt : tgt;
                        state <= FETCH;
                    end else if (redirect) begin
                        tgt <= redirect_tgt;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [15:0] PC_RST = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0000;

    logic        clk;
    logic        reset;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_load;
    logic [15:0] ir_in;
    logic        ir_valid;
    logic [15:0] pc_out;

    fetch_ctrl #(.PC_RESET(PC_RST), .FLUSH_NOP(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ir_load      (ir_load),
        .ir_in        (ir_in),
        .ir_valid     (ir_valid),
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: the next address to fetch, an optional parked word,
    // an optional pending jump target, and what the IR currently holds.
    logic        m_known = 1'b0;
    logic [15:0] m_pc;
    logic        m_parked;
    logic [15:0] m_word;
    logic        m_jump_pending;
    logic [15:0] m_jump;
    logic [15:0] m_pcout;
    logic        m_valid;

    // Last combinational values seen, for the directed scenarios.
    logic        lo_load;
    logic [15:0] lo_in;

    task automatic retire(input logic [15:0] addr);
        m_pcout = addr;
        m_valid = 1'b1;
        m_pc    = addr + 16'd2;
    endtask

    // One clock: apply inputs, check outputs against the model, advance the model, cross the edge.
    task automatic step(input logic r, input logic rs, input logic [15:0] rd,
                        input logic st, input logic rdr, input logic [15:0] rp);
        logic        e_load;
        logic [15:0] e_in;
        logic [15:0] rpm;
        rpm         = rp & 16'hFFFE;
        reset       = r;
        imem_resp   = rs;
        imem_rdata  = rd;
        stall       = st;
        redirect    = rdr;
        redirect_pc = rp;
        #1;
        e_load = 1'b0;
        e_in   = NOP;
        if (r || rdr) begin
            e_load = 1'b1;
            e_in   = NOP;
        end else if (m_parked) begin
            e_load = !st;
            e_in   = m_word;
        end else if (!m_jump_pending) begin
            e_load = rs && !st;
            e_in   = rd;
        end
        lo_load = ir_load;
        lo_in   = ir_in;
        chk("ir_load", {31'd0, ir_load}, {31'd0, e_load});
        if (e_load) chk("ir_in", {16'd0, ir_in}, {16'd0, e_in});
        if (r) begin
            chk("imem_read_rst", {31'd0, imem_read}, 32'd0);
        end else if (m_known) begin
            chk("imem_read", {31'd0, imem_read}, {31'd0, !m_parked});
            chk("imem_address", {16'd0, imem_address}, {16'd0, m_pc});
        end
        if (m_known) begin
            chk("pc_out", {16'd0, pc_out}, {16'd0, m_pcout});
            chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
        end
        // Model update.
        if (r) begin
            m_known        = 1'b1;
            m_pc           = PC_RST;
            m_parked       = 1'b0;
            m_word         = 16'h0000;
            m_jump_pending = 1'b0;
            m_jump         = 16'h0000;
            m_pcout        = 16'h0000;
            m_valid        = 1'b0;
        end else if (rdr) begin
            m_valid = 1'b0;
            if (m_parked) begin
                m_parked = 1'b0;
                m_pc     = rpm;
            end else if (rs) begin
                m_jump_pending = 1'b0;
                m_pc           = rpm;
            end else begin
                m_jump_pending = 1'b1;
                m_jump         = rpm;
            end
        end else if (m_parked) begin
            if (!st) begin
                m_parked = 1'b0;
                retire(m_pc);
            end
        end else if (m_jump_pending) begin
            if (rs) begin
                m_jump_pending = 1'b0;
                m_pc           = m_jump;
            end
        end else if (rs) begin
            if (st) begin
                m_parked = 1'b1;
                m_word   = rd;
            end else begin
                retire(m_pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, 16'h0000, st, 1'b0, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; imem_resp = 1'b0; imem_rdata = 16'h0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0;

        // 1. Reset, then the first fetch lands in the IR.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0);
        chk("rst_load", {31'd0, lo_load}, 32'd1);
        chk("rst_in", {16'd0, lo_in}, {16'd0, NOP});
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_pc_out", {16'd0, pc_out}, 32'h0);
        idle(1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
        chk("t1_load", {31'd0, lo_load}, 32'd1);
        chk("t1_in", {16'd0, lo_in}, 32'h1234);
        chk("t1_pc_out", {16'd0, pc_out}, 32'h0000);
        chk("t1_valid", {31'd0, ir_valid}, 32'd1);
        chk("t1_addr", {16'd0, imem_address}, 32'h0002);

        // 2. Stall at response time parks the word.
        step(1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 16'h0);
        chk("t2_noload", {31'd0, lo_load}, 32'd0);
        chk("t2_read_off", {31'd0, imem_read}, 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("t2_load", {31'd0, lo_load}, 32'd1);
        chk("t2_in", {16'd0, lo_in}, 32'h5678);
        chk("t2_addr", {16'd0, imem_address}, 32'h0004);
        chk("t2_pc_out", {16'd0, pc_out}, 32'h0002);

        // 3. Redirect with a read still in flight.
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h3000);
        chk("t3_flush", {31'd0, lo_load}, 32'd1);
        chk("t3_nop", {16'd0, lo_in}, {16'd0, NOP});
        chk("t3_valid", {31'd0, ir_valid}, 32'd0);
        chk("t3_hold_addr", {16'd0, imem_address}, 32'h0004);
        idle(1'b0);
        step(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
        chk("t3_discard", {31'd0, lo_load}, 32'd0);
        chk("t3_addr", {16'd0, imem_address}, 32'h3000);

        // 4. Redirect coinciding with a response.
        step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h4000);
        chk("t4_nop", {16'd0, lo_in}, {16'd0, NOP});
        chk("t4_addr", {16'd0, imem_address}, 32'h4000);

        // 5. PC wrap; redirect target low bit is dropped.
        step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'hFFFF);
        chk("t5_addr", {16'd0, imem_address}, 32'hFFFE);
        step(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
        chk("t5_wrap", {16'd0, imem_address}, 32'h0000);
        chk("t5_pc_out", {16'd0, pc_out}, 32'hFFFE);

        // 6. Reset while a word is parked.
        step(1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        chk("t6_nop", {16'd0, lo_in}, {16'd0, NOP});
        chk("t6_addr", {16'd0, imem_address}, {16'd0, PC_RST});
        chk("t6_valid", {31'd0, ir_valid}, 32'd0);
        idle(1'b0);
        chk("t6_dropped", {31'd0, lo_load}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic r, rs, st, rdr;
            r   = ($urandom_range(0, 199) == 0);
            rdr = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rs  = !m_parked && ($urandom_range(0, 1) == 1);
            step(r, rs, 16'($urandom), st, rdr, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
